// File: rtl/call_stack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : call_stack_ctrl                                              |
// | Description : Hardware return-address stack for the 19-bit CPU. Holds the  |
// |               newest DEPTH return addresses on-chip in a circular buffer,  |
// |               spills the oldest entry to data memory when a CALL finds     |
// |               the buffer full and refills one entry when a RET finds it    |
// |               empty. The requester is stalled while memory is busy.        |
// | Options     : define CALL_STACK_HWM_EN to add the hwm_o high-water-mark    |
// |               output (maximum of on-chip + spilled entries since reset).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module call_stack_ctrl #(
  parameter int          DEPTH     = 4,
  parameter int          MEM_DEPTH = 128,
  parameter logic [18:0] SP_BASE   = 19'h10100,
  parameter logic [18:0] FAULT_PC  = 19'h00100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        call_i,
  input  logic        ret_i,
  input  logic [18:0] ret_addr_i,
  output logic [18:0] ret_addr_o,
  output logic        ret_valid_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [18:0] mem_addr_o,
  output logic [18:0] mem_wdata_o,
  input  logic [18:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [18:0] sp_o,
`ifdef CALL_STACK_HWM_EN
  output logic [7:0]  hwm_o,
`endif
  output logic        overflow_o,
  output logic        underflow_o
);

  // Widths: buffer index, on-chip occupancy (0..DEPTH), spilled count (0..MEM_DEPTH)
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MEM_DEPTH + 1);

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [SW-1:0] C_MEM_DEPTH = SW'(MEM_DEPTH);
  localparam logic [18:0]   C_SP_STEP   = 19'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPILL = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] count_q,     count_d;
  logic [SW-1:0] spill_cnt_q, spill_cnt_d;
  logic [18:0]   sp_q,        sp_d;
  logic [PW-1:0] top_q,       top_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;
  logic [18:0]   stack_q [DEPTH];
  logic [18:0]   stack_d [DEPTH];

  // Single write port into the buffer, steered by the FSM
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [18:0]   wr_data;

  // Oldest live entry sits count-1 slots below the top (mod DEPTH); when the
  // buffer is full the low count bits are zero and this lands on top+1.
  logic [PW-1:0] oldest_idx;
  assign oldest_idx = top_q - count_q[PW-1:0] + PW'(1);

  assign sp_o        = sp_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // Next-state, datapath control and all combinational outputs
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    spill_cnt_d = spill_cnt_q;
    sp_d        = sp_q;
    top_d       = top_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_idx      = top_q;
    wr_data     = ret_addr_i;
    ret_valid_o = 1'b0;
    ret_addr_o  = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (call_i && ret_i) begin
          // Call and return together: hand back the top and replace it in
          // place; an empty stack simply forwards the incoming address.
          ret_valid_o = 1'b1;
          if (count_q != '0) begin
            ret_addr_o = stack_q[top_q];
            wr_en      = 1'b1;
            wr_idx     = top_q;
          end else begin
            ret_addr_o = ret_addr_i;
          end
        end else if (call_i) begin
          if (count_q != C_DEPTH) begin
            wr_en   = 1'b1;
            wr_idx  = top_q + PW'(1);
            top_d   = top_q + PW'(1);
            count_d = count_q + CW'(1);
          end else if (spill_cnt_q != C_MEM_DEPTH) begin
            // Full on-chip: make room by spilling the oldest, call waits
            stall_o = 1'b1;
            state_d = S_SPILL;
          end else begin
            // Nowhere left to put it: the call is dropped and flagged
            overflow_d = 1'b1;
          end
        end else if (ret_i) begin
          if (count_q != '0) begin
            ret_valid_o = 1'b1;
            ret_addr_o  = stack_q[top_q];
            top_d       = top_q - PW'(1);
            count_d     = count_q - CW'(1);
          end else if (spill_cnt_q != '0) begin
            // Empty on-chip but memory holds entries: refill one first
            stall_o = 1'b1;
            state_d = S_FILL;
          end else begin
            // Genuine underflow: return the fault vector
            ret_valid_o = 1'b1;
            ret_addr_o  = FAULT_PC;
            underflow_d = 1'b1;
          end
        end
      end

      S_SPILL: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = sp_q;
        mem_wdata_o = stack_q[oldest_idx];
        if (mem_ack_i) begin
          count_d     = count_q - CW'(1);
          sp_d        = sp_q - C_SP_STEP;
          spill_cnt_d = spill_cnt_q + SW'(1);
          state_d     = S_IDLE;
        end
      end

      S_FILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = sp_q + C_SP_STEP;
        if (mem_ack_i) begin
          // The buffer is empty, so the refilled entry becomes the only one
          wr_en       = 1'b1;
          wr_idx      = top_q;
          wr_data     = mem_rdata_i;
          count_d     = CW'(1);
          sp_d        = sp_q + C_SP_STEP;
          spill_cnt_d = spill_cnt_q - SW'(1);
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer next-value: copy through, overwrite the single written slot
  always_comb begin
    stack_d = stack_q;
    if (wr_en) begin
      stack_d[wr_idx] = wr_data;
    end
  end

  // Control state registers; reset aborts any memory transaction at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      spill_cnt_q <= '0;
      sp_q        <= SP_BASE;
      top_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      spill_cnt_q <= spill_cnt_d;
      sp_q        <= sp_d;
      top_q       <= top_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address buffer storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

`ifdef CALL_STACK_HWM_EN
  logic [7:0]  hwm_q, hwm_d;
  logic [15:0] occ_d;

  // Track peak total depth (on-chip + spilled), saturating at 255
  always_comb begin
    occ_d = 16'(count_d) + 16'(spill_cnt_d);
    hwm_d = hwm_q;
    if (occ_d > 16'(hwm_q)) begin
      hwm_d = (occ_d > 16'd255) ? 8'hFF : occ_d[7:0];
    end
  end

  // High-water-mark register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule
`default_nettype wire
